// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states, port
// indices and the wait counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DMA  = 1'b1;

   // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 15
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle: one instance per port (core, loader/DMA).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input ready, rdata);
   modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant logic with a last-grant pointer; the pointer resets to DMA so
// the first tie goes to the core.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       fixed_prio,
   output logic [1:0] gnt
);

   logic last_q, last_d;

   always_comb begin
      gnt    = req;
      last_d = last_q;
      if (req == 2'b11) begin
         gnt = (fixed_prio || (last_q == PORT_DMA)) ? 2'b01 : 2'b10;
      end
      if (advance && (gnt != 2'b00)) begin
         last_d = gnt[PORT_DMA];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_DMA;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises core and loader accesses onto one fixed-latency synchronous
// memory; one access at a time, completion signalled by a one-cycle ready.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int FIXED_PRIO  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave core,
   mem_port_arbiter_if.slave dma,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   sel_q;
   logic                   we_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic [1:0][DATA_W-1:0] rdata_q;
   logic [1:0]             gnt;
   logic                   advance;
   logic                   capture;

   rr_arbiter2 u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        ({dma.req, core.req}),
      .advance    (advance),
      .fixed_prio (FIXED_PRIO != 0),
      .gnt        (gnt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      advance = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               advance = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_W'(MEM_LATENCY - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request fields are only sampled on the grant cycle in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= PORT_CORE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (advance) begin
         sel_q   <= gnt[PORT_DMA];
         we_q    <= gnt[PORT_DMA] ? dma.we    : core.we;
         addr_q  <= gnt[PORT_DMA] ? dma.addr  : core.addr;
         wdata_q <= gnt[PORT_DMA] ? dma.wdata : core.wdata;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q[gi] <= '0;
         end else if (capture && (sel_q == 1'(gi))) begin
            rdata_q[gi] <= mem_rdata;
         end
      end
   end

   assign mem_en     = (state_q == ST_ISSUE);
   assign mem_we     = mem_en & we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign busy       = (state_q != ST_IDLE);
   assign core.ready = (state_q == ST_DONE) && (sel_q == PORT_CORE);
   assign dma.ready  = (state_q == ST_DONE) && (sel_q == PORT_DMA);
   assign core.rdata = rdata_q[PORT_CORE];
   assign dma.rdata  = rdata_q[PORT_DMA];

endmodule
